// File: rtl/iot_pkg.sv
// Shared definitions for the IoT event serializer: default sizing, event
// polarity constants, the default device-index type and a popcount helper.
package iot_pkg;

  localparam int N_DEV_DEFAULT = 8;
  localparam int ID_W_DEFAULT  = $clog2(N_DEV_DEFAULT);

  // Polarity carried with each event: connect counts up, disconnect counts down.
  localparam logic EVT_ON  = 1'b1;
  localparam logic EVT_OFF = 1'b0;

  typedef logic [ID_W_DEFAULT-1:0] dev_id_t;

  // Population count over a 32-bit vector (the widest supported port count).
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/iot_rr_arbiter.sv
// Combinational round-robin arbiter. Grants the lowest requesting index at or
// above ptr_i, wrapping to 0. Indices are reduced modulo N, so non-power-of-two
// N never grants a nonexistent device. The caller owns the pointer register.
module iot_rr_arbiter #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Scan N positions starting at the pointer; the first pending request wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(N)) begin
        sum = sum - (ID_W+1)'(N);
      end
      idx = sum[ID_W-1:0];
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        valid_o    = 1'b1;
        idx_o      = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iot_event_serializer.sv
// Collects per-device connect/disconnect strobes into one pending slot per
// device and issues at most one registered change/on_off pulse per cycle,
// round-robin across devices. Same-polarity repeats are dropped and flagged
// in a sticky overflow bit; opposite-polarity repeats cancel.
// Optional feature macro IOT_DEVICE_STATE_EN: tracks a per-device online bit,
// discards events that would not change it, and exposes online_map.
module iot_event_serializer
  import iot_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int ID_W  = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DEV-1:0] dev_evt,
  input  logic [N_DEV-1:0] dev_on,
  input  logic             hold,
  input  logic             clr_overflow,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic [ID_W:0]    pending_cnt,
`ifdef IOT_DEVICE_STATE_EN
  output logic [N_DEV-1:0] online_map,
`endif
  output logic             overflow
);

  logic [N_DEV-1:0] pend_q, pend_d;
  logic [N_DEV-1:0] pol_q, pol_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [ID_W-1:0]  dev_id_q, dev_id_d;
  logic [ID_W:0]    pending_cnt_q, pending_cnt_d;
  logic             overflow_q, overflow_d;
  logic             drop;

  logic [N_DEV-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_valid;

`ifdef IOT_DEVICE_STATE_EN
  logic [N_DEV-1:0] online_q, online_d;
`endif

  // Arbitration looks only at slots already pending; hold suppresses grants.
  iot_rr_arbiter #(
    .N    (N_DEV),
    .ID_W (ID_W)
  ) u_arb (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .en_i    (!hold),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  // Per-device slot update: grant, capture, cancel or drop.
  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    drop   = 1'b0;
`ifdef IOT_DEVICE_STATE_EN
    online_d = online_q;
`endif
    for (int i = 0; i < N_DEV; i++) begin
      if (gnt[i]) begin
        // The old event leaves this cycle; a simultaneous new one takes its place.
`ifdef IOT_DEVICE_STATE_EN
        online_d[i] = pol_q[i];
`endif
        pend_d[i] = dev_evt[i];
        if (dev_evt[i]) begin
          pol_d[i] = dev_on[i];
        end
      end else if (dev_evt[i]) begin
        if (!pend_q[i]) begin
`ifdef IOT_DEVICE_STATE_EN
          // An event restating the device's current state carries no news.
          if (dev_on[i] == online_q[i]) begin
            drop = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
            pol_d[i]  = dev_on[i];
          end
`else
          pend_d[i] = 1'b1;
          pol_d[i]  = dev_on[i];
`endif
        end else if (pol_q[i] != dev_on[i]) begin
          // Connect followed by disconnect (or vice versa) nets to zero.
          pend_d[i] = 1'b0;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Output pulse, pointer advance, overflow and pending count next-state.
  always_comb begin
    change_d      = 1'b0;
    on_off_d      = on_off_q;
    dev_id_d      = dev_id_q;
    ptr_d         = ptr_q;
    if (gnt_valid) begin
      change_d = 1'b1;
      on_off_d = pol_q[gnt_idx];
      dev_id_d = gnt_idx;
      ptr_d    = (gnt_idx == ID_W'(N_DEV - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    pending_cnt_d = (ID_W+1)'(popcount32(32'(pend_d)));
  end

  // State registers; reset discards every pending event at once.
  // NOTE: the per-device slot vectors are ordinary flops and are reset along
  // with everything else, so no stale event survives an asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q        <= '0;
      pol_q         <= '0;
      ptr_q         <= '0;
      change_q      <= 1'b0;
      on_off_q      <= 1'b0;
      dev_id_q      <= '0;
      pending_cnt_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational blocks.
      pend_q        <= pend_d;
      pol_q         <= pol_d;
      ptr_q         <= ptr_d;
      change_q      <= change_d;
      on_off_q      <= on_off_d;
      dev_id_q      <= dev_id_d;
      pending_cnt_q <= pending_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef IOT_DEVICE_STATE_EN
  // Last issued polarity per device.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      online_q <= '0;
    end else begin
      online_q <= online_d;
    end
  end

  assign online_map = online_q;
`endif

  assign change      = change_q;
  assign on_off      = on_off_q;
  assign dev_id      = dev_id_q;
  assign pending_cnt = pending_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_iot_event_serializer.sv
// Directed testbench for iot_event_serializer (N_DEV=8). Build with
// IOT_DEVICE_STATE_EN defined to also exercise online tracking.
module tb_iot_event_serializer;
  import iot_pkg::*;

  localparam int N = N_DEV_DEFAULT;
  localparam int W = ID_W_DEFAULT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] dev_evt;
  logic [N-1:0] dev_on;
  logic         hold;
  logic         clr_overflow;
  logic         change;
  logic         on_off;
  logic [W-1:0] dev_id;
  logic [W:0]   pending_cnt;
  logic         overflow;
`ifdef IOT_DEVICE_STATE_EN
  logic [N-1:0] online_map;
`endif

  int checks = 0;
  int errors = 0;

  iot_event_serializer #(.N_DEV(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dev_evt      (dev_evt),
    .dev_on       (dev_on),
    .hold         (hold),
    .clr_overflow (clr_overflow),
    .change       (change),
    .on_off       (on_off),
    .dev_id       (dev_id),
    .pending_cnt  (pending_cnt),
`ifdef IOT_DEVICE_STATE_EN
    .online_map   (online_map),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    dev_id_t exp_id;
    rst_n        = 1'b0;
    dev_evt      = '0;
    dev_on       = '0;
    hold         = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) step();
    check("rst_change", 32'(change), 0);
    check("rst_on_off", 32'(on_off), 0);
    check("rst_dev_id", 32'(dev_id), 0);
    check("rst_pcnt", 32'(pending_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;

    // Single connect on device 3: two-cycle latency, single pulse.
    dev_evt = 8'h08; dev_on = 8'h08;
    step();
    dev_evt = '0;
    check("t1_change_e1", 32'(change), 0);
    check("t1_pcnt_e1", 32'(pending_cnt), 1);
    step();
    check("t1_change_e2", 32'(change), 1);
    check("t1_on_off", 32'(on_off), 32'(EVT_ON));
    check("t1_dev_id", 32'(dev_id), 3);
    check("t1_pcnt_e2", 32'(pending_cnt), 0);
    step();
    check("t1_change_e3", 32'(change), 0);
    check("t1_id_hold", 32'(dev_id), 3);

    // All eight devices at once from ptr=0: ids 0..7, count 8 then 7..0.
    pulse_reset();
    dev_evt = 8'hFF; dev_on = 8'hFF;
    step();
    dev_evt = '0;
    check("t2_pcnt_full", 32'(pending_cnt), 8);
    check("t2_change0", 32'(change), 0);
    for (int k = 0; k < 8; k++) begin
      step();
      exp_id = dev_id_t'(k);
      check($sformatf("t2_change_%0d", k), 32'(change), 1);
      check($sformatf("t2_id_%0d", k), 32'(dev_id), 32'(exp_id));
      check($sformatf("t2_pcnt_%0d", k), 32'(pending_cnt), 32'(7 - k));
    end
    step();
    check("t2_change_end", 32'(change), 0);

    // Connect then disconnect on device 2 while held: cancelled, no overflow.
    hold = 1'b1;
    dev_evt = 8'h04; dev_on = 8'h04;
    step();
    check("t3_pcnt_a", 32'(pending_cnt), 1);
    dev_evt = 8'h04; dev_on = 8'h00;
    step();
    check("t3_pcnt_b", 32'(pending_cnt), 0);
    dev_evt = '0; hold = 1'b0;
    step();
    check("t3_change_a", 32'(change), 0);
    step();
    check("t3_change_b", 32'(change), 0);
    check("t3_ovf", 32'(overflow), 0);

    // Two connects on device 5 while held: drop, one pulse, then clear.
    hold = 1'b1;
    dev_evt = 8'h20; dev_on = 8'h20;
    step();
    check("t4_ovf_a", 32'(overflow), 0);
    step();
    check("t4_ovf_b", 32'(overflow), 1);
    check("t4_pcnt", 32'(pending_cnt), 1);
    check("t4_change_held", 32'(change), 0);
    dev_evt = '0; hold = 1'b0;
    step();
    check("t4_change", 32'(change), 1);
    check("t4_on_off", 32'(on_off), 1);
    check("t4_dev_id", 32'(dev_id), 5);
    step();
    check("t4_single", 32'(change), 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 0);

    // ptr=6 with devices 1 and 6 pending: 6 first, then wrap to 1.
    hold = 1'b1;
    dev_evt = 8'h42; dev_on = 8'h42;
    step();
    dev_evt = '0;
    check("t5_pcnt", 32'(pending_cnt), 2);
    hold = 1'b0;
    step();
    check("t5_id_first", 32'(dev_id), 6);
    check("t5_change_first", 32'(change), 1);
    step();
    check("t5_id_wrap", 32'(dev_id), 1);
    check("t5_change_wrap", 32'(change), 1);
    step();
    check("t5_idle", 32'(change), 0);

    // Drop coinciding with clear: overflow stays set. Then disconnect issued.
    hold = 1'b1;
    dev_evt = 8'h40; dev_on = 8'h00;
    step();
    clr_overflow = 1'b1;
    step();
    check("t6_drop_wins", 32'(overflow), 1);
    dev_evt = '0;
    step();
    clr_overflow = 1'b0;
    check("t6_clr", 32'(overflow), 0);
    hold = 1'b0;
    step();
    check("t6_change", 32'(change), 1);
    check("t6_dev_id", 32'(dev_id), 6);
    check("t6_on_off", 32'(on_off), 32'(EVT_OFF));
    step();

    // New event on device 0 in the cycle it is granted: both issue, no drop.
    dev_evt = 8'h01; dev_on = 8'h01;
    step();
    dev_evt = 8'h01; dev_on = 8'h00;
    step();
    dev_evt = '0;
    check("t7_change_a", 32'(change), 1);
    check("t7_on_a", 32'(on_off), 1);
    check("t7_id_a", 32'(dev_id), 0);
    check("t7_pcnt_a", 32'(pending_cnt), 1);
    step();
    check("t7_change_b", 32'(change), 1);
    check("t7_on_b", 32'(on_off), 0);
    check("t7_id_b", 32'(dev_id), 0);
    check("t7_ovf", 32'(overflow), 0);
    step();

    // Reset mid-operation with three pending: change drops without a clock.
    hold = 1'b1;
    dev_evt = 8'h1C; dev_on = 8'h1C;
    step();
    dev_evt = '0; hold = 1'b0;
    check("t8_pcnt", 32'(pending_cnt), 3);
    step();
    check("t8_change_pre", 32'(change), 1);
    check("t8_id_pre", 32'(dev_id), 2);
    rst_n = 1'b0;
    #1;
    check("t8_change_async", 32'(change), 0);
    check("t8_pcnt_async", 32'(pending_cnt), 0);
    #1 rst_n = 1'b1;
    step();
    check("t8_after_a", 32'(change), 0);
    step();
    check("t8_after_b", 32'(change), 0);
    check("t8_pcnt_after", 32'(pending_cnt), 0);

`ifdef IOT_DEVICE_STATE_EN
    // Repeat connect on an online device is redundant and flagged.
    dev_evt = 8'h10; dev_on = 8'h10;
    step();
    dev_evt = '0;
    step();
    check("t9_change", 32'(change), 1);
    check("t9_online", 32'(online_map[4]), 1);
    dev_evt = 8'h10; dev_on = 8'h10;
    step();
    dev_evt = '0;
    check("t9_pcnt", 32'(pending_cnt), 0);
    check("t9_ovf", 32'(overflow), 1);
    step();
    check("t9_no_pulse", 32'(change), 0);
    check("t9_online_keep", 32'(online_map[4]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iot_event_serializer.md
Name: iot_event_serializer

Overview:
- Sits directly upstream of the active-device counter.
- Collects connect/disconnect notifications from N_DEV device ports.
- Each port fires independently, and several ports may fire in the same cycle.
- Serialises the notifications into at most one registered change/on_off pulse per cycle, which drives the counter's change and on_off inputs.
- Uses round-robin arbitration with one pending slot per device, and reports drops via a sticky overflow flag.

Parameters:
- N_DEV, 8: number of device ports (2..32).
- ID_W, $clog2(N_DEV): width of dev_id and of the round-robin pointer.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dev_evt  input  N_DEV  per-device event strobe, one cycle per event.
- dev_on  input  N_DEV  polarity qualifying dev_evt[i]; 1 = device connected, 0 = device disconnected.
- hold  input  1  downstream pause; while 1, no grant is issued.
- clr_overflow  input  1  synchronous clear of overflow.
- change  output  1  registered event strobe to the counter.
- on_off  output  1  registered polarity of the granted event; 1 = count up.
- dev_id  output  ID_W  index of the granted device; valid when change=1.
- pending_cnt  output  ID_W+1  number of devices with an event pending.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): every pending flag and polarity bit = 0, rr pointer = 0, change=0, on_off=0, dev_id=0, pending_cnt=0, overflow=0.
- Per-device state: pend[i] and pol[i].
- Capture: dev_evt[i]=1 at edge k updates pend[i]/pol[i] at edge k.
- Arbitration (combinational from pend, when hold=0):
  - Grant the lowest index g ≥ ptr with pend[g]=1; wrap to 0 if none is found above ptr.
  - At the edge, register change=1, on_off=pol[g], dev_id=g.
  - Clear pend[g] and set ptr = (g+1) mod N_DEV.
- No grant (nothing pending, or hold=1): change=0 next cycle; on_off and dev_id hold their previous values.
- Latency: an event sampled at edge k is output for the cycle after edge k+1 at the earliest (2-cycle latency when uncontended). Worst case is N_DEV+1 cycles under full contention.
- Event on an idle slot (pend[i]=0): set pend[i]=1, pol[i]=dev_on[i].
- Event with opposite polarity to a pending, ungranted event: cancel. pend[i] becomes 0, because the net count change is zero.
- Event with the same polarity as a pending, ungranted event: drop the new event, keep the old one, set overflow.
- Event on device i in the same cycle device i is granted: the granted (old) event is issued, and the new event becomes pending with its own polarity. No cancel and no overflow.
- hold=1: pending events still accumulate and the cancel/drop rules still apply; ptr is frozen.
- overflow: clr_overflow=1 clears it. If a drop occurs in the same cycle as the clear, the drop wins and overflow stays 1.
- pending_cnt: registered popcount of pend after the update.
- Width rules:
  - The pointer wraps modulo N_DEV, including non-power-of-two N_DEV.
  - Indices ≥ N_DEV are never granted.
- Reset mid-operation: all pending events are discarded immediately, and change falls asynchronously.

Optional Feature:
- Macro: IOT_DEVICE_STATE_EN.
- When defined:
  - Adds a per-device online bit, reset to 0, updated when a grant issues: online[g] = pol[g].
  - A captured event whose polarity equals the current online[i] with pend[i]=0 is redundant. It is discarded, sets overflow, and is never issued.
  - The cancel rule is unchanged.
  - Adds output online_map[N_DEV].
- When undefined: no online tracking; every surviving event is forwarded; online_map is absent.

Decomposition:
- Package iot_pkg:
  - N_DEV_DEFAULT = 8.
  - EVT_ON = 1'b1, EVT_OFF = 1'b0.
  - typedef dev_id_t sized from N_DEV_DEFAULT.
- Sub-module iot_rr_arbiter:
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, valid.
  - Purely combinational. The parent owns the pointer and the output registers.

Test Plan:
- Reset, then dev_evt[3]=1 with dev_on[3]=1 at edge 1 → change=1, on_off=1, dev_id=3 in the cycle after edge 2; change=0 thereafter.
- All 8 devices fire with polarity 1 in one cycle, ptr=0 → dev_id sequence 0..7 on 8 consecutive cycles; pending_cnt reads 8, then counts down 7..0.
- dev_evt[2] with on=1 while hold=1, then dev_evt[2] with on=0 the next cycle, then release hold → no change pulse, overflow=0.
- dev_evt[5] with on=1 twice while hold=1 → overflow=1; exactly one pulse with on_off=1 after hold releases; clr_overflow → overflow=0.
- ptr=6 with pend={1,6} (N_DEV=8) → dev_id 6, then 1 (wrap-around); rst_n pulled low with 3 events pending → change=0 and pending_cnt=0 immediately, no pulses after release.
- With IOT_DEVICE_STATE_EN defined: connect device 4 (issued), then connect device 4 again → second event discarded, overflow=1, online_map[4]=1.
